interleaver_read_engine: RTL and testbench
==========================================

INTERLEAVER_READ_ENGINE -- requirements
Module: interleaver_read_engine

Interface
REQ-001 SHALL have parameter ROW_NUMBER, default 10, rows per interleaver block.
REQ-002 SHALL have parameter COL_NUMBER, default 7, columns per interleaver block.
REQ-003 SHALL have parameter DATA_WIDTH, default 1, bits per stored symbol.
REQ-004 SHALL have parameter RD_LATENCY, default 1, buffer read latency in cycles, legal range 1..4.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port PING_PONG_FLAG_IN, input, 1 bit, buffer half selected by the writer.
REQ-008 SHALL have port PING_PONG_FLAG_OUT, output, 1 bit, latched buffer half in use.
REQ-009 SHALL have port MODE, input, 1 bit: 0 is row-major read, 1 is column-major (transposed) read.
REQ-010 SHALL have port READ_START, input, 1 bit, writer signals a full block ready.
REQ-011 SHALL have port READ_ACK, output, 1 bit, one-cycle acknowledge of READ_START.
REQ-012 SHALL have port BUFF_ADDR, output, $clog2(ROW_NUMBER*COL_NUMBER) bits, buffer read address.
REQ-013 SHALL have port BUFF_RD, output, 1 bit, buffer read strobe.
REQ-014 SHALL have port BUFF_DATA, input, DATA_WIDTH bits, valid RD_LATENCY cycles after BUFF_RD.
REQ-015 SHALL have port FIFO_DATA, output, DATA_WIDTH bits, symbol to output FIFO.
REQ-016 SHALL have port FIFO_WRITE, output, 1 bit, output FIFO write strobe.
REQ-017 SHALL have port FIFO_FULL, input, 1 bit, output FIFO back-pressure.
REQ-018 SHALL have port BLOCK_DONE, output, 1 bit, one-cycle pulse when last symbol of a block is written.

Function
REQ-019 FSM SHALL have states IDLE, ACK, STREAM, DRAIN; encoding unconstrained; illegal state returns to IDLE.
REQ-020 IDLE -> ACK when READ_START=1; READ_START in any other state SHALL be ignored.
REQ-021 ACK SHALL last one cycle with READ_ACK=1, latching PING_PONG_FLAG_IN and MODE, clearing row/col counters; then -> STREAM.
REQ-022 STREAM SHALL issue one BUFF_RD per cycle whenever skid occupancy plus in-flight reads < RD_LATENCY+1.
REQ-023 Mode 0 address order SHALL be r*COL_NUMBER+c with c fastest; mode 1 order SHALL be r*COL_NUMBER+c with r fastest; generated by counters/accumulators, no multiplier.
REQ-024 After the ROW_NUMBER*COL_NUMBER-th BUFF_RD, STREAM -> DRAIN; BUFF_RD SHALL stay 0 in DRAIN.
REQ-025 Returned data SHALL enter an internal skid FIFO of depth RD_LATENCY+1; no symbol SHALL be lost or duplicated under any FIFO_FULL pattern.
REQ-026 FIFO_WRITE=1 SHALL occur exactly when skid is non-empty and FIFO_FULL=0, FIFO_DATA being skid head, in symbol order.
REQ-027 With FIFO_FULL held 0, throughput SHALL be one symbol per cycle; first FIFO_WRITE RD_LATENCY+1 cycles after first BUFF_RD.
REQ-028 BLOCK_DONE SHALL pulse in the cycle of the final FIFO_WRITE; DRAIN -> IDLE on the next cycle.
REQ-029 READ_START already high at DRAIN -> IDLE SHALL be accepted the cycle after IDLE is entered.
REQ-030 BUFF_ADDR SHALL be 0 whenever BUFF_RD=0; FIFO_DATA SHALL be 0 whenever FIFO_WRITE=0.
REQ-031 PING_PONG_FLAG_OUT SHALL hold its latched value until the next ACK.

Reset
REQ-032 RESET SHALL force IDLE, empty skid, zero in-flight count, zero counters, PING_PONG_FLAG_OUT=0.
REQ-033 During and after RESET, READ_ACK, BUFF_RD, BUFF_ADDR, FIFO_WRITE, FIFO_DATA, BLOCK_DONE SHALL be 0.
REQ-034 RESET mid-block SHALL abandon the block; data returning from reads issued before reset SHALL be discarded.

Configuration
REQ-035 Macro INTERLEAVER_READ_BLOCK_CNT_EN defined SHALL add output BLOCK_COUNT, 16 bits, incremented on each BLOCK_DONE, wrapping 65535->0, reset to 0.
REQ-036 Macro undefined SHALL omit BLOCK_COUNT port and logic; all other behaviour identical.

Verification
REQ-037 10x7, W=1, LAT=1, MODE=0, FIFO_FULL=0 -> BUFF_ADDR 0..69 on 70 consecutive cycles, 70 FIFO_WRITEs in order, one BLOCK_DONE.
REQ-038 Same, MODE=1 -> address sequence 0,7,14,..,63,1,8,..,69; FIFO_DATA matches buffer contents in that order.
REQ-039 LAT=3, W=8, FIFO_FULL toggling 1 every 3rd cycle -> 70 writes, no loss/duplicate, BUFF_RD stalls when skid+in-flight=4.
REQ-040 RESET asserted at symbol 30 -> all outputs 0 next cycle; new READ_START yields full 70-symbol block from address 0.
REQ-041 PING_PONG_FLAG_IN=1 at ACK, toggled to 0 during STREAM -> PING_PONG_FLAG_OUT stays 1 for whole block.
REQ-042 With INTERLEAVER_READ_BLOCK_CNT_EN, three back-to-back blocks -> BLOCK_COUNT=3, READ_ACK pulses exactly three times.

Source files
------------

// File: rtl/interleaver_read_engine_if.sv
// rtl/interleaver_read_engine_if.sv - buffer read port and output FIFO write port bundle
interface interleaver_read_engine_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 1
);
    logic [ADDR_WIDTH-1:0] BUFF_ADDR;
    logic                  BUFF_RD;
    logic [DATA_WIDTH-1:0] BUFF_DATA;
    logic [DATA_WIDTH-1:0] FIFO_DATA;
    logic                  FIFO_WRITE;
    logic                  FIFO_FULL;

    modport master (output BUFF_ADDR, BUFF_RD, FIFO_DATA, FIFO_WRITE,
                    input  BUFF_DATA, FIFO_FULL);
    modport slave  (input  BUFF_ADDR, BUFF_RD, FIFO_DATA, FIFO_WRITE,
                    output BUFF_DATA, FIFO_FULL);
endinterface

// File: rtl/interleaver_read_engine.sv
// rtl/interleaver_read_engine.sv - interleaver block read engine; INTERLEAVER_READ_BLOCK_CNT_EN adds BLOCK_COUNT
module interleaver_read_engine #(
    parameter int ROW_NUMBER = 10,
    parameter int COL_NUMBER = 7,
    parameter int DATA_WIDTH = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PING_PONG_FLAG_IN,
    output logic PING_PONG_FLAG_OUT,
    input  logic MODE,
    input  logic READ_START,
    output logic READ_ACK,
    interleaver_read_engine_if.master bus,
    output logic BLOCK_DONE
`ifdef INTERLEAVER_READ_BLOCK_CNT_EN
    ,
    output logic [15:0] BLOCK_COUNT
`endif
);
    localparam int ADDR_W = $clog2(ROW_NUMBER * COL_NUMBER);
    localparam int ROW_W  = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
    localparam int COL_W  = (COL_NUMBER > 1) ? $clog2(COL_NUMBER) : 1;
    localparam int DEPTH  = RD_LATENCY + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW_NUMBER - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COL_NUMBER - 1);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(COL_NUMBER);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0]  OCC_LIMIT = OCC_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, STREAM, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, pp_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [RD_LATENCY-1:0] rd_pipe_q;
    logic [CNT_W-1:0]      inflight_q, skid_cnt_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] skid_mem [DEPTH];

    logic             push, pop, issue, last_issue, block_done;
    logic [OCC_W-1:0] occupancy;

    // Occupancy credits this cycle's pop so a steady stream never stalls.
    assign push       = rd_pipe_q[RD_LATENCY-1];
    assign pop        = (skid_cnt_q != '0) && !bus.FIFO_FULL && !RESET;
    assign occupancy  = OCC_W'(skid_cnt_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue      = (state_q == STREAM) && (occupancy < OCC_LIMIT) && !RESET;
    assign last_issue = issue && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign block_done = (state_q == DRAIN) && pop && (skid_cnt_q == CNT_W'(1)) && (inflight_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (READ_START) state_d = ACK;
            ACK:     state_d = STREAM;
            STREAM:  if (last_issue) state_d = DRAIN;
            DRAIN:   if (block_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign READ_ACK           = (state_q == ACK) && !RESET;
    assign BLOCK_DONE         = block_done;
    assign PING_PONG_FLAG_OUT = pp_q;
    assign bus.BUFF_RD        = issue;
    assign bus.BUFF_ADDR      = issue ? addr_q : '0;
    assign bus.FIFO_WRITE     = pop;
    assign bus.FIFO_DATA      = pop ? skid_mem[rd_ptr_q] : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            pp_q       <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            rd_pipe_q  <= '0;
            inflight_q <= '0;
            skid_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ACK) begin
                pp_q   <= PING_PONG_FLAG_IN;
                mode_q <= MODE;
                row_q  <= '0;
                col_q  <= '0;
                addr_q <= '0;
            end else if (issue) begin
                if (!mode_q) begin
                    addr_q <= addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end else if (row_q == ROW_LAST) begin
                    // Column wrap: next column's first address is simply its index.
                    row_q  <= '0;
                    col_q  <= col_q + 1'b1;
                    addr_q <= ADDR_W'(col_q) + 1'b1;
                end else begin
                    row_q  <= row_q + 1'b1;
                    addr_q <= addr_q + COL_STEP;
                end
            end
            rd_pipe_q[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(push);
            skid_cnt_q <= skid_cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                skid_mem[wr_ptr_q] <= bus.BUFF_DATA;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
    end

`ifdef INTERLEAVER_READ_BLOCK_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET)           BLOCK_COUNT <= '0;
        else if (block_done) BLOCK_COUNT <= BLOCK_COUNT + 16'd1;
    end
`endif
endmodule

// File: tb/tb_interleaver_read_engine.sv
// tb/tb_interleaver_read_engine.sv - scoreboard bench for interleaver_read_engine (10x7, W=8, LAT=3)
`timescale 1ns/1ps
module tb_interleaver_read_engine;
    localparam int ROWS = 10;
    localparam int COLS = 7;
    localparam int W    = 8;
    localparam int LAT  = 3;
    localparam int N    = ROWS * COLS;
    localparam int AW   = 7;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic PING_PONG_FLAG_IN = 1'b0;
    logic MODE = 1'b0;
    logic READ_START = 1'b0;
    logic PING_PONG_FLAG_OUT, READ_ACK, BLOCK_DONE;
`ifdef INTERLEAVER_READ_BLOCK_CNT_EN
    logic [15:0] BLOCK_COUNT;
`endif

    interleaver_read_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(W)) bus ();

    interleaver_read_engine #(
        .ROW_NUMBER(ROWS), .COL_NUMBER(COLS), .DATA_WIDTH(W), .RD_LATENCY(LAT)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PING_PONG_FLAG_IN(PING_PONG_FLAG_IN),
        .PING_PONG_FLAG_OUT(PING_PONG_FLAG_OUT),
        .MODE(MODE),
        .READ_START(READ_START),
        .READ_ACK(READ_ACK),
        .bus(bus),
        .BLOCK_DONE(BLOCK_DONE)
`ifdef INTERLEAVER_READ_BLOCK_CNT_EN
        ,
        .BLOCK_COUNT(BLOCK_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] mem_val(input logic [AW-1:0] a);
        return {1'b0, a} * 8'd3 + 8'h11;
    endfunction

    // Buffer model: data for an address appears LAT cycles after its read strobe.
    logic [LAT-1:0] pipe_vld = '0;
    logic [AW-1:0]  pipe_addr [LAT];
    always @(posedge CLK) begin
        pipe_vld     <= {pipe_vld[LAT-2:0], bus.BUFF_RD};
        pipe_addr[0] <= bus.BUFF_ADDR;
        for (int i = 1; i < LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
    end
    assign bus.BUFF_DATA = pipe_vld[LAT-1] ? mem_val(pipe_addr[LAT-1]) : 8'hEE;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic full_toggle = 1'b0;
    initial begin
        int c;
        c = 0;
        bus.FIFO_FULL = 1'b0;
        forever begin
            @(posedge CLK);
            c++;
            #1 bus.FIFO_FULL = full_toggle && (c % 3 == 0);
        end
    end

    logic [AW-1:0] exp_addr_q [$];
    logic [W-1:0]  exp_data_q [$];
    logic exp_pp = 1'b0;
    int cyc = 0, ack_cnt = 0, done_cnt = 0, done_since_rst = 0;
    int blk_rd, blk_wr, first_rd, last_rd, first_wr, last_wr, outstanding, max_out;
    int last_done_cyc = 0, ack_gap = 0;

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (RESET) begin
                check("rst_read_ack", READ_ACK, 0);
                check("rst_buff_rd", bus.BUFF_RD, 0);
                check("rst_buff_addr", bus.BUFF_ADDR, 0);
                check("rst_fifo_write", bus.FIFO_WRITE, 0);
                check("rst_fifo_data", bus.FIFO_DATA, 0);
                check("rst_block_done", BLOCK_DONE, 0);
                exp_addr_q.delete();
                exp_data_q.delete();
                exp_pp = 1'b0;
                outstanding = 0;
                done_since_rst = 0;
            end else begin
                if (!READ_ACK) check("pp_flag_out", PING_PONG_FLAG_OUT, exp_pp);
                if (READ_ACK) begin
                    ack_cnt++;
                    ack_gap = cyc - last_done_cyc;
                    exp_pp = PING_PONG_FLAG_IN;
                    blk_rd = 0; blk_wr = 0; first_rd = -1; first_wr = -1; max_out = 0;
                    if (!MODE) begin
                        for (int a = 0; a < N; a++) exp_addr_q.push_back(AW'(a));
                    end else begin
                        for (int c = 0; c < COLS; c++)
                            for (int r = 0; r < ROWS; r++) exp_addr_q.push_back(AW'(r * COLS + c));
                    end
                    foreach (exp_addr_q[i]) exp_data_q.push_back(mem_val(exp_addr_q[i]));
                end
                if (bus.BUFF_RD) begin
                    if (exp_addr_q.size() == 0) check("rd_unexpected", 1, 0);
                    else check("buff_addr", bus.BUFF_ADDR, exp_addr_q.pop_front());
                    if (first_rd < 0) first_rd = cyc;
                    last_rd = cyc;
                    blk_rd++;
                    outstanding++;
                end else begin
                    check("buff_addr_idle", bus.BUFF_ADDR, 0);
                end
                if (bus.FIFO_FULL) check("write_when_full", bus.FIFO_WRITE, 0);
                if (bus.FIFO_WRITE) begin
                    if (exp_data_q.size() == 0) check("wr_unexpected", 1, 0);
                    else check("fifo_data", bus.FIFO_DATA, exp_data_q.pop_front());
                    if (first_wr < 0) first_wr = cyc;
                    last_wr = cyc;
                    blk_wr++;
                    outstanding--;
                end else begin
                    check("fifo_data_idle", bus.FIFO_DATA, 0);
                end
                if (bus.BUFF_RD) check("outstanding_le_4", outstanding <= LAT + 1, 1);
                if (outstanding > max_out) max_out = outstanding;
                if (BLOCK_DONE) begin
                    check("done_with_write", bus.FIFO_WRITE, 1);
                    check("done_queue_empty", exp_data_q.size() + exp_addr_q.size(), 0);
                    done_cnt++;
                    done_since_rst++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic start_block(input logic mode, input logic pp);
        int prev;
        bit got;
        prev = ack_cnt;
        got = 0;
        MODE = mode;
        PING_PONG_FLAG_IN = pp;
        READ_START = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge CLK);
            if (ack_cnt != prev) got = 1;
        end
        #1 READ_START = 1'b0;
        check("ack_seen", got, 1);
    endtask

    task automatic wait_done(input int limit);
        int prev;
        bit got;
        prev = done_cnt;
        got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(posedge CLK);
            if (done_cnt != prev) got = 1;
        end
        #1;
        check("block_done_seen", got, 1);
    endtask

    task automatic check_block(input string tag, input bit full_rate);
        check({tag, "_rd_count"}, blk_rd, N);
        check({tag, "_wr_count"}, blk_wr, N);
        if (full_rate) begin
            check({tag, "_first_wr_latency"}, first_wr - first_rd, LAT + 1);
            check({tag, "_rd_span"}, last_rd - first_rd, N - 1);
            check({tag, "_wr_span"}, last_wr - first_wr, N - 1);
        end else begin
            check({tag, "_max_outstanding"}, max_out, LAT + 1);
            check({tag, "_rd_stalled"}, (last_rd - first_rd) > (N - 1), 1);
        end
    endtask

    initial begin
        int prev_ack, prev_done, n;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Row-major at full rate; flag, mode and a stray start change mid-block.
        start_block(1'b0, 1'b1);
        repeat (5) @(posedge CLK);
        #1 PING_PONG_FLAG_IN = 1'b0; MODE = 1'b1; READ_START = 1'b1;
        @(posedge CLK);
        #1 READ_START = 1'b0;
        wait_done(500);
        check_block("rowmajor", 1);
        check("single_ack", ack_cnt, 1);
        repeat (3) @(posedge CLK);
        #1;

        start_block(1'b1, 1'b0);
        wait_done(500);
        check_block("colmajor", 1);

        full_toggle = 1'b1;
        start_block(1'b0, 1'b1);
        wait_done(1000);
        check_block("rowmajor_bp", 0);
        start_block(1'b1, 1'b0);
        wait_done(1000);
        check_block("colmajor_bp", 0);
        full_toggle = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Abandon a block after 30 symbols; reads already issued must be dropped.
        start_block(1'b1, 1'b1);
        n = 0;
        while (blk_wr < 30 && n < 500) begin
            @(posedge CLK);
            n++;
        end
        check("reached_symbol_30", blk_wr, 30);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (8) @(posedge CLK);
        #1;

        // Three back-to-back blocks with READ_START held high.
        prev_ack = ack_cnt;
        prev_done = done_cnt;
        MODE = 1'b0;
        PING_PONG_FLAG_IN = 1'b1;
        READ_START = 1'b1;
        n = 0;
        while (ack_cnt - prev_ack < 3 && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        #1 READ_START = 1'b0;
        n = 0;
        while (done_cnt - prev_done < 3 && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        repeat (10) @(posedge CLK);
        #1;
        check("b2b_acks", ack_cnt - prev_ack, 3);
        check("b2b_dones", done_cnt - prev_done, 3);
        check("b2b_restart_gap", ack_gap, 2);
        check("b2b_last_wr_count", blk_wr, N);
`ifdef INTERLEAVER_READ_BLOCK_CNT_EN
        check("block_count", BLOCK_COUNT, done_since_rst);
        check("block_count_three", BLOCK_COUNT, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
